// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: operand-forward selects,
// controller FSM states and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } hz_state_e;

    localparam int unsigned X0 = '0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage source operand.
// The younger producer in M wins over W; x0 is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic [RA_W-1:0] rd_m_i,
    input  logic [RA_W-1:0] rd_w_i,
    input  logic            reg_wr_m_i,
    input  logic            reg_wr_w_i,
    output logic [1:0]      sel_o
);

    fwd_sel_e sel;
    logic     hit_m;
    logic     hit_w;

    always_comb begin
        hit_m = reg_wr_m_i && (rd_m_i != RA_W'(X0)) && (rd_m_i == rs_i);
        hit_w = reg_wr_w_i && (rd_w_i != RA_W'(X0)) && (rd_w_i == rs_i);
        sel   = FWD_REG;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
    end

    assign sel_o = sel;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard, forwarding and stall controller for the 5-stage RV32I pipeline:
// M/W forwarding, load-use bubbles, branch squash, data-memory freeze, perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W      = 5,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned MEM_TMO   = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  rs1D,
    input  logic [RA_W-1:0]  rs2D,
    input  logic [RA_W-1:0]  rs1E,
    input  logic [RA_W-1:0]  rs2E,
    input  logic [RA_W-1:0]  rdE,
    input  logic [RA_W-1:0]  rdM,
    input  logic [RA_W-1:0]  rdW,
    input  logic             reg_wrE,
    input  logic             reg_wrM,
    input  logic             reg_wrW,
    input  logic             is_loadE,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             bubbleW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned TMR_W = $clog2(MEM_TMO + 1);

    hz_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       fcnt_q,  fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic mem_block;
    logic stall_f_c, stall_d_c, stall_e_c, stall_m_c;
    logic flush_d_c, flush_e_c, bubble_w_c, mem_err_c;
    logic any_stall;

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .rs_i       (rs1E),
        .rd_m_i     (rdM),
        .rd_w_i     (rdW),
        .reg_wr_m_i (reg_wrM),
        .reg_wr_w_i (reg_wrW),
        .sel_o      (fwdA)
    );

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .rs_i       (rs2E),
        .rd_m_i     (rdM),
        .rd_w_i     (rdW),
        .reg_wr_m_i (reg_wrM),
        .reg_wr_w_i (reg_wrW),
        .sel_o      (fwdB)
    );

    assign lu        = is_loadE && reg_wrE && (rdE != RA_W'(X0)) &&
                       ((rdE == rs1D) || (rdE == rs2D));
    assign mem_block = dmem_req && !dmem_ack;

    // Controls are decoded from the current state and inputs so that the
    // load-use and branch-squash actions land in the cycle the hazard is seen.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fcnt_d     = fcnt_q;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        stall_e_c  = 1'b0;
        stall_m_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        bubble_w_c = 1'b0;
        mem_err_c  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_block) begin
                    state_d = MEM_WAIT;
                    timer_d = '0;
                end else if (br_taken) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = 2'(FLUSH_CYC - 1);
                    end
                end else if (lu) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end

            MEM_WAIT: begin
                stall_f_c  = 1'b1;
                stall_d_c  = 1'b1;
                stall_e_c  = 1'b1;
                stall_m_c  = 1'b1;
                bubble_w_c = 1'b1;
                timer_d    = timer_q + TMR_W'(1);
                if (dmem_ack) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(MEM_TMO - 1)) begin
                    mem_err_c = 1'b1;
                    state_d   = RUN;
                    timer_d   = '0;
                end
            end

            FLUSH: begin
                flush_d_c = 1'b1;
                flush_e_c = 1'b1;
                // The branch target already sits in F, so dropping the
                // remaining squash cycles on a memory freeze is safe.
                if (mem_block) begin
                    state_d = MEM_WAIT;
                    timer_d = '0;
                    fcnt_d  = '0;
                end else if (fcnt_q <= 2'd1) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end

            default: begin
                state_d = RUN;
                timer_d = '0;
                fcnt_d  = '0;
            end
        endcase
    end

    assign stallF  = stall_f_c  && !rst;
    assign stallD  = stall_d_c  && !rst;
    assign stallE  = stall_e_c  && !rst;
    assign stallM  = stall_m_c  && !rst;
    assign flushD  = flush_d_c  && !rst;
    assign flushE  = flush_e_c  && !rst;
    assign bubbleW = bubble_w_c && !rst;
    assign mem_err = mem_err_c  && !rst;

    assign any_stall = stallF || stallD || stallE || stallM;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (any_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flushD && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            timer_q     <= '0;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: default instance plus a FLUSH_CYC=1,
// CNT_W=4 instance for the single-cycle squash and counter saturation cases.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       reg_wrE, reg_wrM, reg_wrW, is_loadE, br_taken, dmem_req, dmem_ack;

    logic [1:0]  fwdA, fwdB, fwdA2, fwdB2;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, bubbleW, mem_err;
    logic        stallF2, stallD2, stallE2, stallM2, flushD2, flushE2, bubbleW2, mem_err2;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt2, flush_cnt2;
    logic [7:0]  ctl, ctl2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_wrE(reg_wrE), .reg_wrM(reg_wrM),
        .reg_wrW(reg_wrW), .is_loadE(is_loadE), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .fwdA(fwdA), .fwdB(fwdB),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .bubbleW(bubbleW), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl_unit #(.FLUSH_CYC(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_wrE(reg_wrE), .reg_wrM(reg_wrM),
        .reg_wrW(reg_wrW), .is_loadE(is_loadE), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .fwdA(fwdA2), .fwdB(fwdB2),
        .stallF(stallF2), .stallD(stallD2), .stallE(stallE2), .stallM(stallM2),
        .flushD(flushD2), .flushE(flushE2), .bubbleW(bubbleW2), .mem_err(mem_err2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    // {stallF, stallD, stallE, stallM, flushD, flushE, bubbleW, mem_err}
    assign ctl  = {stallF, stallD, stallE, stallM, flushD, flushE, bubbleW, mem_err};
    assign ctl2 = {stallF2, stallD2, stallE2, stallM2, flushD2, flushE2, bubbleW2, mem_err2};

    localparam logic [7:0] C_IDLE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_0100;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_MW   = 8'b1111_0010;
    localparam logic [7:0] C_ERR  = 8'b1111_0011;

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        reg_wrE = 0; reg_wrM = 0; reg_wrW = 0; is_loadE = 0;
        br_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    // Entered and left just after a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE);
        else pass_cnt++;
        total_cnt++;
        if ({fwdA, fwdB} !== 4'b0000) $display("FAIL reset_fwd got=%b exp=0000", {fwdA, fwdB});
        else pass_cnt++;
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== 32'd0)
            $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt);
        else pass_cnt++;
    endtask

    task automatic test_forward();
        idle();
        rdM = 5; reg_wrM = 1; rs1E = 5; rs2E = 1;
        #1;
        total_cnt++;
        if ({fwdA, fwdB} !== 4'b1000) $display("FAIL fwd_m got=%b exp=1000", {fwdA, fwdB});
        else pass_cnt++;
        reg_wrM = 0; rdW = 5; reg_wrW = 1;
        #1;
        total_cnt++;
        if (fwdA !== 2'b01) $display("FAIL fwd_w got=%b exp=01", fwdA);
        else pass_cnt++;
        reg_wrM = 1;
        #1;
        total_cnt++;
        if (fwdA !== 2'b10) $display("FAIL fwd_m_prio got=%b exp=10", fwdA);
        else pass_cnt++;
        rdM = 0; rdW = 0; rs1E = 0;
        #1;
        total_cnt++;
        if (fwdA !== 2'b00) $display("FAIL fwd_x0 got=%b exp=00", fwdA);
        else pass_cnt++;
        rs2E = 9; rdW = 9; rdM = 9; reg_wrM = 0;
        #1;
        total_cnt++;
        if ({fwdA, fwdB} !== 4'b0001) $display("FAIL fwd_b_w got=%b exp=0001", {fwdA, fwdB});
        else pass_cnt++;
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        is_loadE = 1; reg_wrE = 1; rdE = 7; rs1D = 7; rs2D = 2;
        #1;
        total_cnt++;
        if (ctl !== C_LU) $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU);
        else pass_cnt++;
        @(negedge clk);
        idle();
        rdM = 7; reg_wrM = 1; rs1E = 7;
        #1;
        total_cnt++;
        if ({ctl, fwdA} !== {C_IDLE, 2'b10})
            $display("FAIL lu_after got ctl=%b fwdA=%b exp ctl=%b fwdA=10", ctl, fwdA, C_IDLE);
        else pass_cnt++;
        idle();
        is_loadE = 1; reg_wrE = 1; rdE = 3; rs1D = 4; rs2D = 3;
        #1;
        total_cnt++;
        if (ctl !== C_LU) $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU);
        else pass_cnt++;
        @(negedge clk);
        rdE = 0; rs1D = 0; rs2D = 0;
        #1;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL lu_x0 got=%b exp=%b", ctl, C_IDLE);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== {16'd2, 16'd0})
            $display("FAIL lu_cnt got stall=%0d flush=%0d exp 2/0", stall_cnt, flush_cnt);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        do_reset();
        br_taken = 1;
        #1;
        total_cnt++;
        if ({ctl, ctl2} !== {C_BR, C_BR}) $display("FAIL br_c0 got=%b/%b exp=%b", ctl, ctl2, C_BR);
        else pass_cnt++;
        @(negedge clk);
        br_taken = 0;
        #1;
        total_cnt++;
        if ({ctl, ctl2} !== {C_BR, C_IDLE})
            $display("FAIL br_c1 got=%b/%b exp=%b/%b", ctl, ctl2, C_BR, C_IDLE);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL br_c2 got=%b exp=%b", ctl, C_IDLE);
        else pass_cnt++;
        total_cnt++;
        if ({flush_cnt, flush_cnt2} !== {16'd2, 4'd1})
            $display("FAIL br_cnt got=%0d/%0d exp 2/1", flush_cnt, flush_cnt2);
        else pass_cnt++;
        br_taken = 1; is_loadE = 1; reg_wrE = 1; rdE = 7; rs1D = 7;
        #1;
        total_cnt++;
        if (ctl !== C_BR) $display("FAIL br_lu got=%b exp=%b", ctl, C_BR);
        else pass_cnt++;
        @(negedge clk);
        idle();
        dmem_req = 1;
        #1;
        total_cnt++;
        if (ctl !== C_BR) $display("FAIL br_pre_flush got=%b exp=%b", ctl, C_BR);
        else pass_cnt++;
        @(negedge clk);
        dmem_ack = 1;
        #1;
        total_cnt++;
        if (ctl !== C_MW) $display("FAIL br_pre_mw got=%b exp=%b", ctl, C_MW);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if ({ctl, flush_cnt} !== {C_IDLE, 16'd4})
            $display("FAIL br_pre_end got ctl=%b flush=%0d exp %b/4", ctl, flush_cnt, C_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req = 1;
        #1;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL mw_c0 got=%b exp=%b", ctl, C_IDLE);
        else pass_cnt++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            dmem_ack = (k == 3);
            #1;
            total_cnt++;
            if (ctl !== C_MW) $display("FAIL mw_c%0d got=%b exp=%b", k, ctl, C_MW);
            else pass_cnt++;
        end
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if ({ctl, stall_cnt} !== {C_IDLE, 16'd3})
            $display("FAIL mw_release got ctl=%b stall=%0d exp %b/3", ctl, stall_cnt, C_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if (ctl !== ((k == 16) ? C_ERR : C_MW))
                $display("FAIL tmo_c%0d got=%b exp=%b", k, ctl, (k == 16) ? C_ERR : C_MW);
            else pass_cnt++;
        end
        @(negedge clk);
        idle();
        #1;
        total_cnt++;
        if ({ctl, stall_cnt} !== {C_IDLE, 16'd16})
            $display("FAIL tmo_run got ctl=%b stall=%0d exp %b/16", ctl, stall_cnt, C_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dmem_req = 1;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        idle();
        #1;
        total_cnt++;
        if ({ctl, stall_cnt, flush_cnt} !== {C_IDLE, 32'd0})
            $display("FAIL rst_mw got ctl=%b stall=%0d flush=%0d exp 0", ctl, stall_cnt, flush_cnt);
        else pass_cnt++;
        br_taken = 1;
        @(negedge clk);
        br_taken = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        total_cnt++;
        if ({ctl, stall_cnt, flush_cnt} !== {C_IDLE, 32'd0})
            $display("FAIL rst_fl got ctl=%b stall=%0d flush=%0d exp 0", ctl, stall_cnt, flush_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        is_loadE = 1; reg_wrE = 1; rdE = 6; rs1D = 6;
        repeat (20) @(negedge clk);
        #1;
        total_cnt++;
        if ({stall_cnt, stall_cnt2} !== {16'd20, 4'hF})
            $display("FAIL sat_20 got=%0d/%0d exp 20/15", stall_cnt, stall_cnt2);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({ctl2, stall_cnt2} !== {C_LU, 4'hF})
            $display("FAIL sat_hold got ctl=%b cnt=%0d exp %b/15", ctl2, stall_cnt2, C_LU);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
